// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state codes and byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_SEND    = 2'd1;
  localparam arb_state_t ARB_WAIT_HI = 2'd2;
  localparam arb_state_t ARB_WAIT_LO = 2'd3;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   pick_o,
  output logic               any_o
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Scan from the farthest candidate down so the nearest one after last_i wins.
  always_comb begin
    pick_o = last_i;
    any_o  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j  = (int'(last_i) + k) % NUM_REQ;
      jj = IDX_W'(j);
      if (req_i[jj]) begin
        pick_o = jj;
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters,
// with packet lock (held until a last byte) and an optional inter-byte lock timeout.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*8-1:0]     req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     uart_tx_en,
  output logic [UART_DATA_W-1:0]   uart_tx_data,
  input  logic                     uart_tx_busy,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     grant_active,
  output logic                     lock_err
);

  localparam int TMO_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (LOCK_TIMEOUT > 0) ? TMO_W'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   last_q, last_d;
  logic                   tx_en_q, tx_en_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   lock_err_q, lock_err_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic [IDX_W-1:0]       pick;
  logic                   any_valid;
  logic                   sel_valid;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .pick_o (pick),
    .any_o  (any_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[8*i +: 8];
        req_ready[i] = (state_q == ARB_SEND);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    last_d       = last_q;
    tx_en_d      = 1'b0;
    tx_data_d    = tx_data_q;
    lock_err_d   = 1'b0;
    tmo_d        = tmo_q;
    case (state_q)
      ARB_IDLE: begin
        // Never grant while a frame is still on the wire.
        if (!uart_tx_busy && any_valid) begin
          grant_d = pick;
          tmo_d   = '0;
          state_d = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (sel_valid) begin
          tx_data_d = sel_data;
          tx_en_d   = 1'b1;
          last_d    = sel_last;
          tmo_d     = '0;
          state_d   = ARB_WAIT_HI;
        end else begin
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
          if (LOCK_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            lock_err_d   = 1'b1;
            last_grant_d = grant_q;
            tmo_d        = '0;
            state_d      = ARB_IDLE;
          end
        end
      end
      ARB_WAIT_HI: begin
        if (uart_tx_busy) state_d = ARB_WAIT_LO;
      end
      ARB_WAIT_LO: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            last_grant_d = grant_q;
            state_d      = ARB_IDLE;
          end else begin
            state_d = ARB_SEND;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      last_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      lock_err_q   <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      lock_err_q   <= lock_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign grant_idx    = grant_q;
  assign grant_active = (state_q != ARB_IDLE);
  assign lock_err     = lock_err_q;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART byte transmitter among NUM_REQ byte-stream requesters.
- Accepts bytes over per-requester valid/ready handshakes and drives the transmitter's enable/data pair. It pulses the enable only when the transmitter is idle.
- Supports packet lock: once granted, a requester keeps the UART until it sends a byte flagged last, or until a lock timeout expires.
- Sits between the system debug/log sources and the UART byte transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; equals clog2(NUM_REQ).
- LOCK_TIMEOUT, 100000, cycles a locked requester may stall between bytes before the lock is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i]
- req_last  in  NUM_REQ  byte of requester i ends its packet
- req_ready  out  NUM_REQ  byte of requester i accepted when valid&ready
- uart_tx_en  out  1  one-cycle start pulse to the transmitter
- uart_tx_data  out  8  byte to the transmitter; held stable until the next transfer
- uart_tx_busy  in  1  transmitter busy; rises the cycle after it samples uart_tx_en
- grant_idx  out  IDX_W  index of the current or last granted requester
- grant_active  out  1  high when state is not IDLE
- lock_err  out  1  one-cycle pulse when a lock times out

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All state is registered.
- Reset values:
  - state=IDLE, uart_tx_en=0, uart_tx_data=0, grant_idx=0, lock_err=0, timeout counter=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- req_ready[i] is combinational: (state==SEND) && (grant_idx==i). It does not depend on req_valid.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - Arbitrates only when uart_tx_busy==0 and any req_valid is set. This protects a frame still in flight after a controller-only reset.
  - Picks the first valid requester scanning from last_grant+1, wrapping modulo NUM_REQ.
  - Registers the pick into grant_idx and goes to SEND. This costs one cycle of arbitration latency.
- SEND:
  - On req_valid[grant_idx] (transfer): uart_tx_data<=req_data[grant_idx], uart_tx_en<=1, capture last_q<=req_last[grant_idx], clear the timeout counter, go to WAIT_HI.
  - Without valid: increment the timeout counter. If LOCK_TIMEOUT!=0 and counter==LOCK_TIMEOUT-1: lock_err<=1, last_grant<=grant_idx, go to IDLE.
- WAIT_HI:
  - uart_tx_en<=0, so the enable is exactly one cycle wide.
  - Waits for uart_tx_busy==1, then goes to WAIT_LO.
- WAIT_LO:
  - Waits for uart_tx_busy==0.
  - If last_q: last_grant<=grant_idx, go to IDLE. Otherwise go to SEND; the lock is held and other requesters are not considered.
- Minimum byte-to-byte spacing within a packet: the transmitter frame time plus 3 cycles.
- Simultaneous valid on several requesters: exactly one is granted. The others see ready=0 and must hold their data.
- A requester with valid high in IDLE but not picked gets no ready; there is no starvation, because every requester is reached within NUM_REQ packets.
- A single-byte packet is a byte with req_last=1 on its only transfer.
- Reset mid-frame:
  - FSM returns to IDLE and uart_tx_en drops.
  - uart_tx_data is cleared; the transmitter has already latched it.
  - No new grant is issued until busy falls.
- Timeout counter width is clog2(LOCK_TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding constants: ARB_IDLE, ARB_SEND, ARB_WAIT_HI, ARB_WAIT_LO.
  - Byte width constant UART_DATA_W=8.
- One natural sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector and last_grant.
  - Outputs: pick index and any-valid flag.
  - Reusable by other arbiters.

Test Plan:
- Bench setup for all scenarios: transmitter model with CLK_FREQ/UART_BPS=16, LOCK_TIMEOUT=40.
- Single byte: after reset, req0 sends 0x55 with last=1 -> one uart_tx_en pulse, uart_tx_data=0x55, req_ready[0] high for 1 cycle, IDLE after busy falls, last_grant=0.
- Round robin: req0..3 valid together, each with one last byte 0xA0..0xA3 -> transmitted order A0,A1,A2,A3; a second identical burst again starts at req0.
- Packet lock: req1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) while req2 holds 0x99 valid -> 11,22,33 then 99; no interleaving.
- Timeout: req3 sends 0x01 with last=0, then deasserts valid -> lock_err pulses exactly 40 cycles after SEND re-entry; req0 then granted.
- Busy guard: hold uart_tx_busy=1 externally, assert rst for 1 cycle, then req0 valid -> no uart_tx_en until busy=0; afterwards normal send.
- Enable width: during any transfer -> uart_tx_en never high for 2 consecutive cycles and never asserted while uart_tx_busy=1.
